ysyx_22050368_ifu: RTL and testbench



---
 rtl/ysyx_22050368_pkg.sv | 22 ++
 rtl/ysyx_22050368_ifu.sv | 114 +++++++++++
 tb/tb_ysyx_22050368_ifu.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050368_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC default,
// instruction width default and the fetch FSM state encoding.
package ysyx_22050368_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned INST_W_DEF = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  // Fetch FSM: issue request, wait for data, drain a killed fetch, hold output.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

  // Instructions are 4-byte aligned; low address bits are forced to zero.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22050368_ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one imem request in
// flight, and presents each fetched instruction to decode via valid/ready.
// A redirect from the branch/jump unit kills wrong-path work and restarts
// fetch at the (aligned) target.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   redirect_valid, redirect_pc     jump pulse and target
//   imem_req_valid/ready/addr       fetch request channel
//   imem_resp_valid/data            fetch response (one per accepted request)
//   if_valid/ready, if_pc, if_inst  instruction to decode
//   err_misalign                    pulse: redirect target was not aligned
module ysyx_22050368_ifu
  import ysyx_22050368_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned INST_W   = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [63:0]       if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              err_misalign
);

  ifu_state_e        state, state_n;
  logic [63:0]       pc_q, pc_n;
  logic              out_valid_q, out_valid_n;
  logic [63:0]       if_pc_n;
  logic [INST_W-1:0] if_inst_n;
  logic              err_n;

  // Request and decode-valid are killed combinationally by a redirect so no
  // wrong-path transfer happens in the redirect cycle itself.
  assign imem_req_valid = rst_n & (state == S_REQ) & ~redirect_valid;
  assign imem_req_addr  = pc_q;
  assign if_valid       = out_valid_q & ~redirect_valid;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_REQ;
      pc_q         <= RESET_PC;
      out_valid_q  <= 1'b0;
      if_pc        <= 64'd0;
      if_inst      <= INST_W'(0);
      err_misalign <= 1'b0;
    end else begin
      state        <= state_n;
      pc_q         <= pc_n;
      out_valid_q  <= out_valid_n;
      if_pc        <= if_pc_n;
      if_inst      <= if_inst_n;
      err_misalign <= err_n;
    end
  end

  // Next-state and datapath update; redirect overrides every state.
  always_comb begin
    state_n     = state;
    pc_n        = pc_q;
    out_valid_n = out_valid_q;
    if_pc_n     = if_pc;
    if_inst_n   = if_inst;
    err_n       = 1'b0;

    if (redirect_valid) begin
      pc_n        = align_pc(redirect_pc);
      err_n       = |redirect_pc[1:0];
      out_valid_n = 1'b0;
      case (state)
        S_REQ:          state_n = S_REQ;
        // An in-flight request must still be drained before refetching.
        S_WAIT, S_DROP: state_n = imem_resp_valid ? S_REQ : S_DROP;
        S_OUT:          state_n = S_REQ;
        default:        state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_valid && imem_req_ready) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if_inst_n   = imem_resp_data;
            if_pc_n     = pc_q;
            out_valid_n = 1'b1;
            pc_n        = pc_q + 64'd4;
            state_n     = S_OUT;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) state_n = S_REQ;
        end
        S_OUT: begin
          if (if_valid && if_ready) begin
            out_valid_n = 1'b0;
            state_n     = S_REQ;
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050368_ifu.sv
// Testbench for ysyx_22050368_ifu: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (next expected PC, outstanding request count,
// expected misalign pulse, hold-while-stalled).
module tb_ysyx_22050368_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        err_misalign;

  ysyx_22050368_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .err_misalign   (err_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk(name, act === exp, act, exp);
  endtask

  // imem responder state
  bit          pend = 0;
  int          cnt  = 0;
  int          lat  = 1;
  logic [63:0] paddr = 64'd0;
  bit          spur_en = 0;

  // snapshot of DUT outputs in the current cycle
  logic        s_rv, s_iv, s_err, s_hs;
  logic [63:0] s_ra, s_ipc;
  logic [31:0] s_iinst;

  // One clock cycle: drive inputs just after the edge, snapshot outputs,
  // then advance the imem responder across the next edge.
  task automatic step(input logic rst, input logic rr, input logic ir,
                      input logic rv, input logic [63:0] rpc);
    rst_n           = rst;
    imem_req_ready  = rr;
    if_ready        = ir;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'($urandom);
    if (pend) begin
      if (cnt <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = inst_of(paddr);
      end else begin
        cnt--;
      end
    end else if (spur_en && $urandom_range(0, 9) == 0) begin
      imem_resp_valid = 1'b1;
    end
    #2;
    s_rv    = imem_req_valid;
    s_ra    = imem_req_addr;
    s_iv    = if_valid;
    s_ipc   = if_pc;
    s_iinst = if_inst;
    s_err   = err_misalign;
    s_hs    = imem_req_valid & imem_req_ready;
    @(posedge clk);
    #1;
    if (imem_resp_valid) pend = 0;
    if (s_hs) begin
      pend  = 1;
      cnt   = lat;
      paddr = s_ra;
    end
    if (!rst) pend = 0;
  endtask

  task automatic wait_req(input logic [63:0] exp, input string name);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
      if (s_hs) begin
        got = 1;
        chk_eq(name, s_ra, exp);
      end
    end
    if (!got) chk({name, "_timeout"}, 1'b0, 64'd0, 64'd1);
  endtask

  task automatic wait_out(input logic [63:0] exp, input logic ir, input string name);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1'b1, 1'b1, ir, 1'b0, 64'd0);
      if (s_iv) begin
        got = 1;
        chk_eq({name, "_pc"}, s_ipc, exp);
        chk_eq({name, "_inst"}, 64'(s_iinst), 64'(inst_of(exp)));
      end
    end
    if (!got) chk({name, "_timeout"}, 1'b0, 64'd0, 64'd1);
  endtask

  // Behavioural model, checked every cycle while out of reset.
  bit          model_on   = 0;
  logic [63:0] exp_pc     = RST_PC;
  int          outst      = 0;
  logic        exp_err    = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_pc    = 64'd0;
  logic [31:0] prev_inst  = 32'd0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_pc     = RST_PC;
      outst      = 0;
      exp_err    = 1'b0;
      prev_stall = 1'b0;
      model_on   = 1;
    end else if (model_on) begin
      chk_eq("m_err_misalign", 64'(err_misalign), 64'(exp_err));
      if (imem_req_valid) begin
        chk_eq("m_req_addr", imem_req_addr, exp_pc);
        chk("m_req_outstanding", outst == 0, 64'(outst), 64'd0);
        chk("m_req_while_if_valid", !if_valid, 64'(if_valid), 64'd0);
        chk("m_req_during_redirect", !redirect_valid, 64'(redirect_valid), 64'd0);
      end
      if (if_valid) begin
        chk_eq("m_if_pc", if_pc, exp_pc);
        chk_eq("m_if_inst", 64'(if_inst), 64'(inst_of(if_pc)));
        chk("m_if_valid_during_redirect", !redirect_valid, 64'(redirect_valid), 64'd0);
      end
      if (prev_stall) begin
        chk_eq("m_hold_valid", 64'(if_valid), 64'(!redirect_valid));
        chk_eq("m_hold_pc", if_pc, prev_pc);
        chk_eq("m_hold_inst", 64'(if_inst), 64'(prev_inst));
      end
      if (imem_resp_valid && outst > 0) outst--;
      if (imem_req_valid && imem_req_ready) outst++;
      prev_stall = if_valid & ~if_ready;
      prev_pc    = if_pc;
      prev_inst  = if_inst;
      exp_err    = redirect_valid & (|redirect_pc[1:0]);
      if (redirect_valid) begin
        exp_pc = {redirect_pc[63:2], 2'b00};
      end else if (if_valid && if_ready) begin
        exp_pc = exp_pc + 64'd4;
        n_deliv++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic rr, ir, rv, rs;
    logic [63:0] rpc;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0; if_ready = 1'b0;
    @(posedge clk); #1;

    // reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_eq("rst_req_valid", 64'(s_rv), 64'd0);
    chk_eq("rst_if_valid", 64'(s_iv), 64'd0);
    chk_eq("rst_if_pc", s_ipc, 64'd0);
    chk_eq("rst_if_inst", 64'(s_iinst), 64'd0);
    chk_eq("rst_err", 64'(s_err), 64'd0);

    // sequential fetch
    wait_req(64'h8000_0000, "seq_req0");
    wait_out(64'h8000_0000, 1'b1, "seq_out0");
    wait_req(64'h8000_0004, "seq_req1");
    wait_out(64'h8000_0004, 1'b1, "seq_out1");
    wait_req(64'h8000_0008, "seq_req2");
    wait_out(64'h8000_0008, 1'b1, "seq_out2");

    // imem not ready: request held stable
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 64'd0);
      chk_eq("stall_req_valid", 64'(s_rv), 64'd1);
      chk_eq("stall_req_addr", s_ra, 64'h8000_000C);
      chk_eq("stall_if_valid", 64'(s_iv), 64'd0);
    end
    wait_req(64'h8000_000C, "stall_req");

    // decode not ready: output held, no new request
    wait_out(64'h8000_000C, 1'b0, "bp_out");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
      chk_eq("bp_if_valid", 64'(s_iv), 64'd1);
      chk_eq("bp_if_pc", s_ipc, 64'h8000_000C);
      chk_eq("bp_if_inst", 64'(s_iinst), 64'(inst_of(64'h8000_000C)));
      chk_eq("bp_req_valid", 64'(s_rv), 64'd0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_eq("bp_release", 64'(s_iv), 64'd1);

    // redirect while waiting; late response is dropped
    lat = 3;
    wait_req(64'h8000_0010, "drop_req");
    step(1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0100);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
      chk_eq("drop_req_valid", 64'(s_rv), 64'd0);
      chk_eq("drop_if_valid", 64'(s_iv), 64'd0);
    end
    lat = 1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_eq("drop_next_valid", 64'(s_rv), 64'd1);
    chk_eq("drop_next_addr", s_ra, 64'h8000_0100);
    wait_out(64'h8000_0100, 1'b1, "drop_out");

    // redirect in the same cycle as the response
    wait_req(64'h8000_0104, "same_req");
    step(1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0200);
    chk_eq("same_if_valid0", 64'(s_iv), 64'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_eq("same_if_valid1", 64'(s_iv), 64'd0);
    chk_eq("same_next_valid", 64'(s_rv), 64'd1);
    chk_eq("same_next_addr", s_ra, 64'h8000_0200);
    wait_out(64'h8000_0200, 1'b1, "same_out");

    // misaligned redirect kills a presented instruction
    wait_req(64'h8000_0204, "kill_req");
    wait_out(64'h8000_0204, 1'b0, "kill_out");
    step(1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0102);
    chk_eq("kill_if_valid", 64'(s_iv), 64'd0);
    chk_eq("kill_err_before", 64'(s_err), 64'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_eq("kill_err_pulse", 64'(s_err), 64'd1);
    chk_eq("kill_next_valid", 64'(s_rv), 64'd1);
    chk_eq("kill_next_addr", s_ra, 64'h8000_0100);
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
    chk_eq("kill_err_clear", 64'(s_err), 64'd0);
    wait_out(64'h8000_0100, 1'b1, "kill_refetch");

    // redirect in S_REQ and PC wrap-around
    step(1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_eq("wrap_redirect_req_valid", 64'(s_rv), 64'd0);
    wait_req(64'hFFFF_FFFF_FFFF_FFFC, "wrap_req");
    wait_out(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, "wrap_out");
    wait_req(64'h0, "wrap_req0");
    wait_out(64'h0, 1'b1, "wrap_out0");

    // randomized traffic
    spur_en = 1;
    for (int c = 0; c < 4000; c++) begin
      rr  = ($urandom_range(0, 9) < 7);
      ir  = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rs  = !($urandom_range(0, 999) == 0);
      lat = int'($urandom_range(1, 4));
      case ($urandom_range(0, 3))
        0:       rpc = 64'h8000_0000 + 64'($urandom_range(0, 1023));
        1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        2:       rpc = {32'($urandom), 32'($urandom)};
        default: rpc = RST_PC + 64'($urandom_range(0, 63)) * 64'd4;
      endcase
      if (!rs) rv = 1'b0;
      step(rs, rr, ir, rv, rpc);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
    chk("liveness_deliveries", n_deliv > 200, 64'(n_deliv), 64'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
